instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/cpu_pkg.sv | 15 +
 rtl/branch_target.sv | 32 +++
 rtl/signExtend.sv | 12 +
 rtl/instr_fetch_unit.sv | 71 +++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: FSM state encoding, PC geometry and reset vector.
package cpu_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_t;

    localparam int PC_WIDTH    = 64;
    localparam int INSTR_WIDTH = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

endpackage

// File: rtl/branch_target.sv
// PC-relative branch adder: B uses imm26, CBZ/B.cond use imm19; offsets count words.
module branch_target
    import cpu_pkg::*;
(
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   UncondBr,
    output logic [PC_WIDTH-1:0]    target
);

    logic [PC_WIDTH-1:0] uncond_offset;
    logic [PC_WIDTH-1:0] cond_offset;
    logic [PC_WIDTH-1:0] offset;
    logic                unused_opcode_bits;

    signExtend #(.IN_WIDTH(26), .OUT_WIDTH(PC_WIDTH)) u_sext_uncond (
        .value_i (instr[25:0]),
        .value_o (uncond_offset)
    );

    signExtend #(.IN_WIDTH(19), .OUT_WIDTH(PC_WIDTH)) u_sext_cond (
        .value_i (instr[23:5]),
        .value_o (cond_offset)
    );

    // The major opcode field selects nothing here; control has already decoded it.
    assign unused_opcode_bits = ^instr[31:26];

    assign offset = UncondBr ? uncond_offset : cond_offset;
    assign target = pc + (offset << 2);

endmodule

// File: rtl/signExtend.sv
// Replicates the top bit of a narrow two's-complement field up to the full width.
module signExtend #(
    parameter int IN_WIDTH  = 19,
    parameter int OUT_WIDTH = 64
) (
    input  logic [IN_WIDTH-1:0]  value_i,
    output logic [OUT_WIDTH-1:0] value_o
);

    assign value_o = {{(OUT_WIDTH - IN_WIDTH){value_i[IN_WIDTH-1]}}, value_i};

endmodule

// File: rtl/instr_fetch_unit.sv
// Two-state fetch/issue sequencer: fetches one instruction, presents it for issue,
// then advances the PC sequentially or to a branch target.
module instr_fetch_unit
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_valid,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] OPCode,
    output logic                   NOOP,
    input  logic                   BrTaken,
    input  logic                   UncondBr,
    input  logic                   stall,
    output logic [31:0]            instr_count
);

    fetch_state_t           state_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [PC_WIDTH-1:0]    pc_d;
    logic [PC_WIDTH-1:0]    branch_pc;
    logic [INSTR_WIDTH-1:0] opcode_q;
    logic [31:0]            count_q;

    branch_target u_branch_target (
        .pc       (pc_q),
        .instr    (opcode_q),
        .UncondBr (UncondBr),
        .target   (branch_pc)
    );

    assign pc_d = BrTaken ? branch_pc : pc_q + PC_WIDTH'(INSTR_BYTES);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // so the PC update and the state change see the same cycle's inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            opcode_q <= '0;
            count_q  <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_valid) begin
                        opcode_q <= imem_data;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A stalled issue freezes everything, including any branch decision.
                    if (!stall) begin
                        pc_q    <= pc_d;
                        count_q <= count_q + 32'd1;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign NOOP        = (state_q == FETCH) || stall;
    assign OPCode      = opcode_q;
    assign instr_count = count_q;

endmodule
